// File: rtl/if_align_buffer_if.sv
// rtl/if_align_buffer_if.sv - fetch/decode handshake bundle for the instruction align buffer
interface if_align_buffer_if;
    logic        fetch_valid;
    logic [31:0] fetch_word;
    logic        fetch_ready;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic        id_compressed;
    logic [31:0] id_pc;

    // Drives fetch words, redirects and decode acceptance (fetch/decode side).
    modport master (
        output fetch_valid, fetch_word, jmp, jmp_pc, id_ready,
        input  fetch_ready, id_valid, id_instr, id_compressed, id_pc
    );

    // The align buffer itself.
    modport slave (
        input  fetch_valid, fetch_word, jmp, jmp_pc, id_ready,
        output fetch_ready, id_valid, id_instr, id_compressed, id_pc
    );
endinterface

// File: rtl/if_align_buffer.sv
// rtl/if_align_buffer.sv - halfword queue aligning RV32IC instructions between fetch and decode
module if_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0100,
    parameter int          DEPTH_HW = 4
) (
    input logic             clk,
    input logic             reset,
    if_align_buffer_if.slave bus
);

    logic [15:0] q_q [DEPTH_HW];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic        drop_low_q, drop_low_d;

    logic [15:0] hw0;
    logic [15:0] hw1;
    logic        is_compressed;
    logic        instr_valid;
    logic        push;
    logic        pop;
    logic [2:0]  push_hw;
    logic [2:0]  pop_hw;

    assign hw0           = q_q[rd_ptr_q];
    assign hw1           = q_q[rd_ptr_q + 2'd1];
    assign is_compressed = (hw0[1:0] != 2'b11);
    assign instr_valid   = (count_q >= 3'd1 && is_compressed) || (count_q >= 3'd2 && !is_compressed);

    // Acceptance uses registered count only, so a push never overwrites halfwords being read.
    assign bus.fetch_ready = (count_q <= 3'd2);
    assign push            = bus.fetch_valid && bus.fetch_ready && !bus.jmp;
    assign pop             = instr_valid && bus.id_ready && !bus.jmp;
    assign push_hw         = !push ? 3'd0 : (drop_low_q ? 3'd1 : 3'd2);
    assign pop_hw          = !pop ? 3'd0 : (is_compressed ? 3'd1 : 3'd2);

    assign bus.id_valid      = instr_valid;
    assign bus.id_compressed = instr_valid && is_compressed;
    assign bus.id_instr      = !instr_valid ? 32'h0 : (is_compressed ? {16'h0, hw0} : {hw1, hw0});
    assign bus.id_pc         = head_pc_q;

    // Next-state for pointers, occupancy and head PC; a redirect overrides any push/pop.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        head_pc_d  = head_pc_q;
        drop_low_d = drop_low_q;
        if (bus.jmp) begin
            rd_ptr_d   = 2'd0;
            wr_ptr_d   = 2'd0;
            count_d    = 3'd0;
            head_pc_d  = bus.jmp_pc & ~32'd1;
            drop_low_d = bus.jmp_pc[1];
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + push_hw[1:0];
                drop_low_d = 1'b0;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + pop_hw[1:0];
                head_pc_d = head_pc_q + (is_compressed ? 32'd2 : 32'd4);
            end
            count_d = count_q + push_hw - pop_hw;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            head_pc_q  <= RESET_PC;
            drop_low_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_pc_q  <= head_pc_d;
            drop_low_q <= drop_low_d;
        end
    end

    // Halfword storage; after a halfword-aligned redirect only the upper half of the word is kept.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            if (drop_low_q) begin
                q_q[wr_ptr_q] <= bus.fetch_word[31:16];
            end else begin
                q_q[wr_ptr_q]        <= bus.fetch_word[15:0];
                q_q[wr_ptr_q + 2'd1] <= bus.fetch_word[31:16];
            end
        end
    end

endmodule

// File: tb/tb_if_align_buffer.sv
// tb/tb_if_align_buffer.sv - scoreboard bench for if_align_buffer
module tb_if_align_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk;
    logic reset;
    if_align_buffer_if bus ();

    if_align_buffer #(.RESET_PC(RESET_PC), .DEPTH_HW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        comp;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] pc;
    } hw_t;

    exp_t        exp_q[$];
    hw_t         pend_q[$];
    logic [31:0] next_pc;
    logic        drop_m;
    bit          model_live;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int buffered_hw();
        int n = pend_q.size();
        foreach (exp_q[i]) n += exp_q[i].comp ? 1 : 2;
        return n;
    endfunction

    function automatic logic [31:0] head_pc_m();
        if (exp_q.size() > 0) return exp_q[0].pc;
        if (pend_q.size() > 0) return pend_q[0].pc;
        return next_pc;
    endfunction

    // Reference: halfwords are an address-ordered stream; instructions are carved off by length.
    task automatic model_append(input logic [15:0] hw);
        hw_t  h;
        exp_t e;
        h.hw = hw;
        h.pc = next_pc;
        pend_q.push_back(h);
        next_pc += 32'd2;
        while (pend_q.size() > 0) begin
            if (pend_q[0].hw[1:0] != 2'b11) begin
                e.instr = {16'h0, pend_q[0].hw};
                e.comp  = 1'b1;
                e.pc    = pend_q[0].pc;
                exp_q.push_back(e);
                void'(pend_q.pop_front());
            end else if (pend_q.size() >= 2) begin
                e.instr = {pend_q[1].hw, pend_q[0].hw};
                e.comp  = 1'b0;
                e.pc    = pend_q[0].pc;
                exp_q.push_back(e);
                void'(pend_q.pop_front());
                void'(pend_q.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic model_flush(input logic [31:0] pc, input logic drop);
        exp_q.delete();
        pend_q.delete();
        next_pc = pc;
        drop_m  = drop;
    endtask

    // Monitor: checks outputs mid-cycle, then advances the model for the coming edge.
    always @(negedge clk) begin
        logic [31:0] w;
        bit          fire_pop;
        bit          fire_push;
        if (reset) begin
            model_flush(RESET_PC, 1'b0);
            model_live = 1'b1;
        end else if (model_live) begin
            chk("fetch_ready", {31'd0, bus.fetch_ready}, {31'd0, buffered_hw() <= 2});
            if (exp_q.size() > 0) begin
                chk("id_valid", {31'd0, bus.id_valid}, 32'd1);
                chk("id_instr", bus.id_instr, exp_q[0].instr);
                chk("id_compressed", {31'd0, bus.id_compressed}, {31'd0, exp_q[0].comp});
                chk("id_pc", bus.id_pc, exp_q[0].pc);
            end else begin
                chk("id_valid_idle", {31'd0, bus.id_valid}, 32'd0);
                chk("id_instr_idle", bus.id_instr, 32'd0);
                chk("id_compressed_idle", {31'd0, bus.id_compressed}, 32'd0);
                chk("id_pc_idle", bus.id_pc, head_pc_m());
            end
            fire_pop  = (exp_q.size() > 0) && bus.id_ready && !bus.jmp;
            fire_push = bus.fetch_valid && (buffered_hw() <= 2) && !bus.jmp;
            if (bus.jmp) begin
                model_flush(bus.jmp_pc & ~32'd1, bus.jmp_pc[1]);
            end else begin
                if (fire_pop) void'(exp_q.pop_front());
                if (fire_push) begin
                    w = bus.fetch_word;
                    if (!drop_m) model_append(w[15:0]);
                    model_append(w[31:16]);
                    drop_m = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic fv, input logic [31:0] w, input logic rdy,
                         input logic j, input logic [31:0] jp);
        @(posedge clk);
        #1;
        bus.fetch_valid = fv;
        bus.fetch_word  = w;
        bus.id_ready    = rdy;
        bus.jmp         = j;
        bus.jmp_pc      = jp;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        return h;
    endfunction

    initial begin
        checks      = 0;
        errors      = 0;
        model_live  = 1'b0;
        next_pc     = RESET_PC;
        drop_m      = 1'b0;
        reset       = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_word  = 32'h0;
        bus.id_ready    = 1'b0;
        bus.jmp         = 1'b0;
        bus.jmp_pc      = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Two 32-bit words, one per cycle.
        drive(1, 32'h00A0_0093, 1, 0, 0);
        drive(1, 32'h00B0_0113, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        // Two compressed in one word.
        drive(1, 32'h4001_4501, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        // Straddle across a word boundary, decode stalled until both words arrive.
        drive(1, 32'h0093_4501, 1, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0);
        drive(1, 32'h4501_0000, 1, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 0);
        // Backpressure: fill to four halfwords, then drain.
        repeat (4) drive(1, 32'h00C0_0193, 0, 0, 0);
        repeat (5) drive(0, 0, 1, 0, 0);
        // Halfword-aligned redirect with a non-empty queue.
        drive(1, 32'h00D0_0213, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0000_0202);
        drive(1, 32'h4505_FFFF, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        // Redirect coinciding with a valid pop and push.
        drive(1, 32'h00E0_0293, 0, 0, 0);
        drive(1, 32'h00F0_0313, 1, 1, 32'h0000_0400);
        repeat (2) drive(0, 0, 1, 0, 0);
        drive(1, 32'h0100_0393, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);

        // Randomized traffic with occasional redirects and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            drive($urandom_range(9, 0) < 7,
                  {rand_hw(), rand_hw()},
                  $urandom_range(9, 0) < 6,
                  $urandom_range(39, 0) == 0,
                  32'h0000_1000 + 32'($urandom_range(255, 0)));
        end
        repeat (6) drive(0, 0, 1, 0, 0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_align_buffer.md
Name: if_align_buffer

Overview:
- Sits between the instruction fetch stage and the decode stage of the RV32IC pipeline.
- Accepts 32-bit fetched words and buffers them as halfwords in a 4-entry queue.
- Delivers one aligned instruction per handshake: either a 16-bit compressed instruction or a 32-bit instruction that may straddle a word boundary.
- Tracks each instruction's PC and handles redirects (jumps/branches), including halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0100: PC of the first instruction after reset; equals the first word fetched.
- DEPTH_HW, 4: queue depth in halfwords. Fixed at 4; other values are unsupported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fetch_valid  input  1  fetch_word holds a valid fetched word
- fetch_word  input  32  fetched word; [15:0] is the lower-address halfword
- fetch_ready  output  1  buffer can accept a word this cycle
- jmp  input  1  redirect (flush) request
- jmp_pc  input  32  redirect target; bit 0 is ignored
- id_valid  output  1  id_instr/id_pc hold a complete instruction
- id_ready  input  1  decode consumes the instruction this cycle
- id_instr  output  32  instruction; compressed instructions are zero-extended {16'h0, hw}
- id_compressed  output  1  id_instr is a 16-bit instruction
- id_pc  output  32  PC of id_instr

Behaviour:
- Storage:
  - Circular queue of 4 halfwords with 2-bit rd_ptr and wr_ptr (wrap modulo 4) and a 3-bit count (0..4).
  - Registers: head_pc (32b) and drop_low (1b).
- Reset:
  - count=0, rd_ptr=0, wr_ptr=0, head_pc=RESET_PC, drop_low=0.
  - Resulting outputs: id_valid=0, id_compressed=0, id_instr=0, id_pc=RESET_PC, fetch_ready=1.
- fetch_ready = (count <= 2). It depends on registered count only, never on same-cycle pops.
- Push: occurs when fetch_valid & fetch_ready & ~jmp.
  - drop_low=0: write [15:0] then [31:16]; count += 2.
  - drop_low=1: write [31:16] only; count += 1; clear drop_low.
- Instruction decode of the head halfword hw0 = q[rd_ptr], with hw1 = q[rd_ptr+1]:
  - compressed when hw0[1:0] != 2'b11.
  - id_valid = (count>=1 & compressed) | (count>=2 & ~compressed).
  - id_instr = compressed ? {16'h0, hw0} : {hw1, hw0}.
  - id_pc = head_pc.
  - When id_valid=0, id_instr=0 and id_compressed=0.
- Pop: occurs when id_valid & id_ready & ~jmp.
  - Advance rd_ptr and head_pc by 1 halfword / +2 (compressed) or 2 halfwords / +4 (32-bit).
  - Decrement count by the same number of halfwords.
- Push and pop in the same cycle:
  - count_next = count + pushed − popped.
  - The pushed data must not corrupt entries being read this cycle; guaranteed because push requires count<=2.
- A 32-bit instruction with only its low halfword buffered (count=1) holds id_valid=0 until the next push. It then issues with id_pc at the original halfword address; this is the boundary-straddle case.
- Redirect (jmp=1), highest priority:
  - Next cycle: count=0, rd_ptr=wr_ptr=0, head_pc={jmp_pc[31:1],1'b0}, drop_low=jmp_pc[1].
  - Any push or pop in the jmp cycle is discarded; decode flushes its own state.
  - The first word accepted after a redirect is the word containing the target.
- jmp together with reset: reset wins.
- Reset asserted mid-operation discards all buffered halfwords.
- No PC wrap handling is needed beyond natural 32-bit overflow.

Test Plan:
- Reset, then push words 0x00A00093, 0x00B00113 -> id_valid after the first push; id_pc=0x100 then 0x104; id_compressed=0; id_ready=1 gives one instruction per cycle.
- Push word 0x40014501 (two compressed: 0x4501, 0x4001) -> two instructions at id_pc 0x100 and 0x102, id_instr=0x00004501 then 0x00004001, id_compressed=1.
- Mixed straddle: push 0x00934501 then 0x45010000 -> 0x4501 @0x100, then 32-bit 0x00000093 @0x102 (valid only after the second push), then 0x4501 @0x106.
- Backpressure: hold id_ready=0 and push 32-bit words -> fetch_ready drops to 0 when count=4 (after two pushes); no data loss; draining returns fetch_ready=1 when count<=2.
- Redirect to halfword target: with the queue non-empty, pulse jmp with jmp_pc=0x202, then push 0x4505FFFF -> queue flushed; only 0x4505 issues with id_pc=0x202; the low halfword 0xFFFF is dropped.
- jmp in the same cycle as a valid pop and push -> neither takes effect; next cycle id_valid=0, count=0, id_pc=jmp_pc.
